// File: rtl/branch_seq_pkg.sv
// Shared types and constants for the 6502 relative-branch sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package branch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ADD_LO = 3'd2,
        ST_FIX_HI = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Flag selected by opcode[7:6]
    localparam logic [1:0] SEL_N = 2'b00;
    localparam logic [1:0] SEL_V = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_Z = 2'b11;

    // Every Bcc opcode has the form xxx10000
    localparam logic [7:0] BRANCH_OPC_MASK = 8'h1F;
    localparam logic [7:0] BRANCH_OPC_VAL  = 8'h10;

    // 6502 cycle counts: not taken, taken same page, taken across a page
    localparam int CYC_NT = 2;
    localparam int CYC_T  = 3;
    localparam int CYC_PX = 4;

    function automatic logic is_branch_opc(input logic [7:0] opc);
        return (opc & BRANCH_OPC_MASK) == BRANCH_OPC_VAL;
    endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// Operand-fetch bus between the branch sequencer and the memory interface.
// Latency: none (wires only); bus_data is valid in the same cycle as bus_ack.
// Backpressure: the requester holds bus_req/bus_addr until bus_ack is seen.
interface branch_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ack;
    logic [7:0]        bus_data;

    modport master (
        output bus_req,
        output bus_addr,
        input  bus_ack,
        input  bus_data
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        output bus_ack,
        output bus_data
    );
endinterface

// File: rtl/branch_sequencer_cond_eval.sv
// Bcc condition test: selects N/V/C/Z from sel[2:1] and compares it with sel[0].
// Latency: combinational.
// Backpressure: none.
module branch_cond_eval
    import branch_seq_pkg::*;
(
    input  logic [2:0] sel_i,
    input  logic       c_i,
    input  logic       v_i,
    input  logic       n_i,
    input  logic       z_i,
    output logic       taken_o
);

    logic flag;

    // Pick the tested flag and compare against the wanted polarity
    always_comb begin
        flag = n_i;
        case (sel_i[2:1])
            SEL_N:   flag = n_i;
            SEL_V:   flag = v_i;
            SEL_C:   flag = c_i;
            SEL_Z:   flag = z_i;
            default: flag = n_i;
        endcase
        taken_o = (flag == sel_i[0]);
    end

endmodule

// File: rtl/branch_sequencer.sv
// 6502 relative-branch sequencer: operand fetch, condition test, target PC, cycle count.
// Latency: done 2/3/4 cycles after start acceptance (+1 per cycle of bus_ack wait).
// Backpressure: ready=0 while busy (start ignored); FETCH stalls until bus_ack. Option: BRANCH_IRQ_DELAY_EN.
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 3
) (
    input  logic                CLK,
    input  logic                n_RES,
    input  logic                start,
    input  logic [7:0]          opcode,
    input  logic [ADDR_W-1:0]   pc_in,
    input  logic                c_flag,
    input  logic                v_flag,
    input  logic                n_flag,
    input  logic                z_flag,
    branch_sequencer_if.master  bus,
    output logic                ready,
    output logic                done,
    output logic                taken,
    output logic                page_cross,
    output logic [ADDR_W-1:0]   target,
    output logic [CNT_W-1:0]    cycles,
    output logic                err,
    output logic                irq_poll_inhibit
);

    localparam int HI_W = ADDR_W - 8;

    state_t              state_q, state_d;
    logic [7:0]          opc_q, opc_d;
    logic [3:0]          flags_q, flags_d;     // {c, v, n, z}
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [7:0]          off_q, off_d;
    logic                taken_q, taken_d;
    logic                px_q, px_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic                err_q, err_d;

    logic                cond_true;
    logic [8:0]          lo_sum;
    logic [HI_W-1:0]     pc_hi;

    branch_cond_eval u_cond (
        .sel_i   (opc_q[7:5]),
        .c_i     (flags_q[3]),
        .v_i     (flags_q[2]),
        .n_i     (flags_q[1]),
        .z_i     (flags_q[0]),
        .taken_o (cond_true)
    );

    // Low-byte add; carry combined with the offset sign tells whether the page changes
    assign lo_sum = {1'b0, pc_q[7:0]} + {1'b0, off_q};
    assign pc_hi  = pc_q[ADDR_W-1:8];

    // Next-state and datapath updates for every state
    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        flags_d  = flags_q;
        pc_d     = pc_q;
        off_d    = off_q;
        taken_d  = taken_q;
        px_d     = px_q;
        target_d = target_q;
        cycles_d = cycles_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opc_d    = opcode;
                    flags_d  = {c_flag, v_flag, n_flag, z_flag};
                    pc_d     = pc_in + ADDR_W'(1);
                    taken_d  = 1'b0;
                    px_d     = 1'b0;
                    target_d = '0;
                    cycles_d = '0;
                    err_d    = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.bus_ack) begin
                    off_d = bus.bus_data;
                    pc_d  = pc_q + ADDR_W'(1);
                    if (!is_branch_opc(opc_q)) begin
                        err_d    = 1'b1;
                        taken_d  = 1'b0;
                        target_d = pc_q + ADDR_W'(1);
                        cycles_d = CNT_W'(CYC_NT);
                        state_d  = ST_DONE;
                    end else if (cond_true) begin
                        taken_d = 1'b1;
                        state_d = ST_ADD_LO;
                    end else begin
                        target_d = pc_q + ADDR_W'(1);
                        cycles_d = CNT_W'(CYC_NT);
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_ADD_LO: begin
                target_d = {pc_hi, lo_sum[7:0]};
                px_d     = lo_sum[8] ^ off_q[7];
                if (lo_sum[8] ^ off_q[7]) begin
                    state_d = ST_FIX_HI;
                end else begin
                    cycles_d = CNT_W'(CYC_T);
                    state_d  = ST_DONE;
                end
            end
            ST_FIX_HI: begin
                // High part wraps modulo 2^ADDR_W without any flag
                target_d = {(off_q[7] ? pc_hi - HI_W'(1) : pc_hi + HI_W'(1)),
                            target_q[7:0]};
                cycles_d = CNT_W'(CYC_PX);
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any branch in flight
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state_q  <= ST_IDLE;
            opc_q    <= '0;
            flags_q  <= '0;
            pc_q     <= '0;
            off_q    <= '0;
            taken_q  <= 1'b0;
            px_q     <= 1'b0;
            target_q <= '0;
            cycles_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            flags_q  <= flags_d;
            pc_q     <= pc_d;
            off_q    <= off_d;
            taken_q  <= taken_d;
            px_q     <= px_d;
            target_q <= target_d;
            cycles_q <= cycles_d;
            err_q    <= err_d;
        end
    end

    assign ready        = (state_q == ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign bus.bus_req  = (state_q == ST_FETCH);
    assign bus.bus_addr = pc_q;
    assign taken        = taken_q;
    assign page_cross   = px_q;
    assign target       = target_q;
    assign cycles       = cycles_q;
    assign err          = err_q;

`ifdef BRANCH_IRQ_DELAY_EN
    // A taken branch that stays in its page delays the interrupt poll by one instruction
    assign irq_poll_inhibit = done & taken_q & ~px_q;
`else
    assign irq_poll_inhibit = 1'b0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: reset values, branch outcomes, latency, reset abort.
// Latency: measured in clock cycles from the start-accepting edge to done.
// Backpressure: bus_ack wait states and ignored start pulses while busy.
module tb_branch_sequencer;

    logic        CLK;
    logic        n_RES;
    logic        start;
    logic [7:0]  opcode;
    logic [15:0] pc_in;
    logic        c_flag, v_flag, n_flag, z_flag;
    logic        ready, done, taken, page_cross, err, irq_poll_inhibit;
    logic [15:0] target;
    logic [2:0]  cycles;

    int n_assert = 0;
    int n_fail   = 0;

    branch_sequencer_if #(.ADDR_W(16)) bif ();

    branch_sequencer #(.ADDR_W(16), .CNT_W(3)) dut (
        .CLK              (CLK),
        .n_RES            (n_RES),
        .start            (start),
        .opcode           (opcode),
        .pc_in            (pc_in),
        .c_flag           (c_flag),
        .v_flag           (v_flag),
        .n_flag           (n_flag),
        .z_flag           (z_flag),
        .bus              (bif.master),
        .ready            (ready),
        .done             (done),
        .taken            (taken),
        .page_cross       (page_cross),
        .target           (target),
        .cycles           (cycles),
        .err              (err),
        .irq_poll_inhibit (irq_poll_inhibit)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One branch: start at a negedge, accepted at the next posedge (cycle k),
    // then cycle k+i is sampled at its negedge. ack is held low for ack_wait
    // FETCH cycles, during which start is also pulsed to check it is ignored.
    task automatic run_op(input string tag, input logic [7:0] opc, input logic [15:0] pc,
                          input logic [3:0] cvnz, input logic [7:0] data, input int ack_wait,
                          input int exp_lat, input logic exp_taken, input logic exp_px,
                          input logic [15:0] exp_target, input logic [2:0] exp_cyc,
                          input logic exp_err);
        int   lat;
        logic exp_irq;
`ifdef BRANCH_IRQ_DELAY_EN
        exp_irq = exp_taken & ~exp_px;
`else
        exp_irq = 1'b0;
`endif
        lat = 0;
        @(negedge CLK);
        start = 1'b1;
        opcode = opc;
        pc_in = pc;
        {c_flag, v_flag, n_flag, z_flag} = cvnz;
        bif.bus_data = data;
        bif.bus_ack = 1'b0;
        chk({tag, ".ready_idle"}, ready, 1);
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge CLK);
            start = (i <= ack_wait);
            bif.bus_ack = (i > ack_wait);
            if (i == 1) begin
                chk({tag, ".bus_req"}, bif.bus_req, 1);
                chk({tag, ".bus_addr"}, bif.bus_addr, pc + 16'd1);
                chk({tag, ".target_clr"}, target, 0);
                chk({tag, ".ready_busy"}, ready, 0);
            end
            if (done) begin
                lat = i;
                chk({tag, ".taken"}, taken, exp_taken);
                chk({tag, ".page_cross"}, page_cross, exp_px);
                chk({tag, ".target"}, target, exp_target);
                chk({tag, ".cycles"}, cycles, exp_cyc);
                chk({tag, ".err"}, err, exp_err);
                chk({tag, ".irq"}, irq_poll_inhibit, exp_irq);
            end
        end
        chk({tag, ".latency"}, lat, exp_lat);
        start = 1'b0;
        @(negedge CLK);
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".target_hold"}, target, exp_target);
    endtask

    initial begin
        int done_cnt;
        n_RES = 1'b0;
        start = 1'b0;
        opcode = 8'h00;
        pc_in = 16'h0000;
        {c_flag, v_flag, n_flag, z_flag} = 4'b0000;
        bif.bus_ack = 1'b0;
        bif.bus_data = 8'h00;

        // Reset values
        #12;
        chk("rst.ready", ready, 1);
        chk("rst.done", done, 0);
        chk("rst.bus_req", bif.bus_req, 0);
        chk("rst.target", target, 0);
        chk("rst.cycles", cycles, 0);
        chk("rst.flags", {taken, page_cross, err, irq_poll_inhibit}, 0);
        @(negedge CLK);
        n_RES = 1'b1;

        //      tag      opc    pc        cvnz     data  wait lat tk px target    cyc err
        run_op("bne_t",  8'hD0, 16'h1000, 4'b0000, 8'h05, 0,  3, 1, 0, 16'h1007, 3, 0);
        run_op("beq_nt", 8'hF0, 16'h1000, 4'b0000, 8'h05, 0,  2, 0, 0, 16'h1002, 2, 0);
        run_op("bcc_px", 8'h90, 16'h10F0, 4'b0000, 8'h20, 0,  4, 1, 1, 16'h1112, 4, 0);
        run_op("bpl_px", 8'h10, 16'h1000, 4'b0000, 8'hF0, 0,  4, 1, 1, 16'h0FF2, 4, 0);
        run_op("bne_w3", 8'hD0, 16'h1000, 4'b0000, 8'h05, 3,  6, 1, 0, 16'h1007, 3, 0);
        run_op("illegal",8'hA9, 16'h2000, 4'b1000, 8'h05, 0,  2, 0, 0, 16'h2002, 2, 1);
        run_op("bmi_wrp",8'h30, 16'hFFF0, 4'b0010, 8'h20, 0,  4, 1, 1, 16'h0012, 4, 0);
        run_op("bcs_bk", 8'hB0, 16'h1050, 4'b1000, 8'hFE, 0,  3, 1, 0, 16'h1050, 3, 0);
        run_op("bvc_nt", 8'h50, 16'h3000, 4'b0100, 8'h40, 0,  2, 0, 0, 16'h3002, 2, 0);

        // Reset during FIX_HI: BCC page-cross, accepted at k, FIX_HI is cycle k+3
        @(negedge CLK);
        start = 1'b1; opcode = 8'h90; pc_in = 16'h10F0;
        {c_flag, v_flag, n_flag, z_flag} = 4'b0000;
        bif.bus_data = 8'h20; bif.bus_ack = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_fix.busy", ready, 0);
        n_RES = 1'b0;
        #1;
        chk("rst_fix.ready", ready, 1);
        chk("rst_fix.page_cross", page_cross, 0);
        chk("rst_fix.target", target, 0);
        chk("rst_fix.cycles", cycles, 0);
        @(negedge CLK);
        n_RES = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (done) done_cnt++;
        end
        chk("rst_fix.no_done", done_cnt, 0);

        // Reset during FETCH drops bus_req at once
        @(negedge CLK);
        start = 1'b1; opcode = 8'hD0; pc_in = 16'h4000;
        bif.bus_ack = 1'b0;
        @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        chk("rst_fetch.req_on", bif.bus_req, 1);
        n_RES = 1'b0;
        #1;
        chk("rst_fetch.req_off", bif.bus_req, 0);
        chk("rst_fetch.ready", ready, 1);
        @(negedge CLK);
        n_RES = 1'b1;
        bif.bus_ack = 1'b1;

        // Normal operation after the aborts
        run_op("post_rst", 8'hD0, 16'h1000, 4'b0000, 8'h05, 0, 3, 1, 0, 16'h1007, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Single-clock sequencer for 6502 relative branches (Bcc opcodes xxx10000). On start it fetches the signed offset operand over a request/acknowledge bus, evaluates the flag condition and computes the target PC. It applies the 6502 cycle timing: 2 cycles not-taken, 3 cycles taken in the same page, 4 cycles taken across a page. It sits between the instruction decoder and the PC/address-bus logic.

Parameters:
ADDR_W, 16, PC/bus address width; minimum 9; page size fixed at 256 bytes
CNT_W, 3, width of the cycle-count output

Ports:
CLK  in  1  single system clock; all state updates on rising edge
n_RES  in  1  asynchronous active-low reset
start  in  1  begin branch; accepted only when ready=1
opcode  in  8  branch opcode; sampled on start acceptance
pc_in  in  ADDR_W  address of the opcode byte; sampled on start acceptance
c_flag, v_flag, n_flag, z_flag  in  1 each  processor flags; sampled on start acceptance
bus_req  out  1  operand fetch request
bus_addr  out  ADDR_W  operand address (pc_in+1)
bus_ack  in  1  fetch complete; bus_data valid in the same cycle
bus_data  in  8  operand byte (signed offset)
ready  out  1  idle, can accept start
done  out  1  one-cycle pulse; result outputs valid
taken  out  1  branch condition true
page_cross  out  1  target is in a different 256-byte page than pc_in+2
target  out  ADDR_W  next PC
cycles  out  CNT_W  instruction cycle count (2/3/4)
err  out  1  opcode was not xxx10000
irq_poll_inhibit  out  1  see Optional Feature

Behaviour:
- Reset (n_RES=0, async): state IDLE, ready=1. bus_req, done, taken, page_cross, err, irq_poll_inhibit=0. target=0, cycles=0. An operation in flight is abandoned and no done is produced. bus_req deasserts immediately.
- States: IDLE, FETCH, ADD_LO, FIX_HI, DONE.
- IDLE: ready=1. When start=1, latch opcode, flags and pc_reg=pc_in+1, then go to FETCH. start is ignored in every other state, including DONE.
- FETCH: bus_req=1, bus_addr=pc_reg. Hold until bus_ack=1; bus_ack is ignored outside FETCH.
- On ack: off=bus_data and pc_reg=pc_reg+1. Condition: opcode[7:6] selects the flag (00 N, 01 V, 10 C, 11 Z); taken = (flag == opcode[5]).
- On ack with illegal opcode (opcode[4:0]!=10000): err=1 and taken=0.
- On ack, not taken: go to DONE with target=pc_reg (already +2), cycles=2.
- On ack, taken: go to ADD_LO.
- ADD_LO: {carry, lo} = pc_reg[7:0] + off; target low byte = lo. page_cross = carry XOR off[7]. No cross: target high part = pc_reg high part, cycles=3, go to DONE. Cross: go to FIX_HI.
- FIX_HI: high part = pc_reg high part +1 if off[7]=0, else -1. Arithmetic is modulo 2^ADDR_W, so 0xFFxx to 0x00xx wraps silently. cycles=4, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Result outputs hold their values until the next start is accepted. They clear to 0 at acceptance.
- Latency with bus_ack tied 1, start accepted at cycle k: done at k+2 (not-taken), k+3 (taken, same page), k+4 (taken, page cross). Each cycle of ack wait adds 1.

Optional Feature:
BRANCH_IRQ_DELAY_EN. When defined, irq_poll_inhibit=1 together with done when taken=1 and page_cross=0, modelling the 6502 delayed interrupt poll. When not defined, irq_poll_inhibit is tied to 0. The port exists in both builds.

Decomposition:
- Package branch_seq_pkg holds:
  - the state enum;
  - flag-select constants (SEL_N/V/C/Z);
  - BRANCH_OPC_MASK=8'h1F and BRANCH_OPC_VAL=8'h10;
  - cycle constants CYC_NT=2, CYC_T=3, CYC_PX=4.
- One combinational sub-module, branch_cond_eval (opcode[7:5] plus four flags in, taken out), reused by other flag-test logic.

Test Plan:
1. BNE (D0), Z=0, pc_in=0x1000, bus_data=0x05, ack tied 1 -> done at k+3, taken=1, target=0x1007, page_cross=0, cycles=3.
2. BEQ (F0), Z=0, pc_in=0x1000 -> done at k+2, taken=0, target=0x1002, cycles=2, bus_addr was 0x1001.
3. BCC (90), C=0, pc_in=0x10F0, data=0x20 -> target=0x1112, page_cross=1, cycles=4, done at k+4. BPL (10), N=0, pc_in=0x1000, data=0xF0 -> target=0x0FF2, page_cross=1, cycles=4.
4. bus_ack held 0 for 3 cycles after FETCH entry -> done at k+6 on taken/no-cross; start pulses while busy are ignored. n_RES low during FIX_HI -> immediate IDLE, ready=1, no done.
5. opcode=0xA9 -> err=1, taken=0, cycles=2. With BRANCH_IRQ_DELAY_EN, case 1 gives irq_poll_inhibit=1 with done and case 3 gives 0. Without the macro, irq_poll_inhibit is always 0.
